// File: rtl/trace_pkg.sv
// Shared types for the retirement trace unit: record kinds, the trace record
// layout, FSM states and the retire classifier.
package trace_pkg;

    localparam int unsigned TR_DATA_W = 16;
    localparam int unsigned TR_REG_W  = 4;
    localparam int unsigned TR_CNT_W  = 32;

    typedef enum logic [2:0] {
        OTHER   = 3'd0,
        REGWR   = 3'd1,
        LOAD    = 3'd2,
        STORE   = 3'd3,
        HALT    = 3'd4,
        TIMEOUT = 3'd5
    } trace_kind_t;

    typedef struct packed {
        trace_kind_t             kind;
        logic [TR_CNT_W-1:0]     inum;
        logic [TR_DATA_W-1:0]    pc;
        logic [TR_REG_W-1:0]     reg_idx;
        logic [TR_DATA_W-1:0]    value;
        logic [TR_DATA_W-1:0]    addr;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic trace_kind_t classify(input logic h, input logic rw,
                                             input logic mr, input logic mw);
        if (h)        return HALT;
        if (rw && mr) return LOAD;
        if (rw)       return REGWR;
        if (mw)       return STORE;
        return OTHER;
    endfunction

endpackage

// File: rtl/retire_trace_unit_if.sv
// Retire/trace bus of the trace unit; master = core + trace sink, slave = unit.
interface retire_trace_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned CNT_W  = 32
);
    logic              run;
    logic              retire_valid;
    logic [DATA_W-1:0] retire_pc;
    logic [DATA_W-1:0] retire_inst;
    logic              reg_write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              halt;
    logic              stall;
    logic              trace_valid;
    logic              trace_ready;
    logic [2:0]        trace_kind;
    logic [CNT_W-1:0]  trace_inum;
    logic [DATA_W-1:0] trace_pc;
    logic [REG_W-1:0]  trace_reg;
    logic [DATA_W-1:0] trace_value;
    logic [DATA_W-1:0] trace_addr;
    logic [CNT_W-1:0]  inst_count;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  dropped;
    logic              overflow;
    logic              timeout;
    logic              done;

    modport master (
        output run, retire_valid, retire_pc, retire_inst, reg_write, write_reg,
               write_data, mem_read, mem_write, mem_addr, mem_data, halt, trace_ready,
        input  stall, trace_valid, trace_kind, trace_inum, trace_pc, trace_reg,
               trace_value, trace_addr, inst_count, cycle_count, dropped, overflow,
               timeout, done
    );

    modport slave (
        input  run, retire_valid, retire_pc, retire_inst, reg_write, write_reg,
               write_data, mem_read, mem_write, mem_addr, mem_data, halt, trace_ready,
        output stall, trace_valid, trace_kind, trace_inum, trace_pc, trace_reg,
               trace_value, trace_addr, inst_count, cycle_count, dropped, overflow,
               timeout, done
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records; an extra pointer bit separates full from empty.
module trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    T           r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        w_wr_en;
    logic        w_rd_en;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_rd_en = i_pop && !o_empty;
    // A pop frees the head slot in the same cycle, so a full FIFO may still take a push.
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
            if (w_rd_en) r_rd <= r_rd + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/retire_trace_unit.sv
// Retirement monitor: classifies retires into trace records, counts, watchdog, halt/done.
// Optional macro TRACE_STALL_EN: backpressure the core instead of dropping records.
module retire_trace_unit
    import trace_pkg::*;
#(
    parameter int unsigned DATA_W      = TR_DATA_W,
    parameter int unsigned REG_W       = TR_REG_W,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CNT_W       = TR_CNT_W,
    parameter int unsigned CYCLE_LIMIT = 100000
) (
    input  logic                clk,
    input  logic                rst,
    retire_trace_unit_if.slave  bus
);
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_inst_count;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_dropped;
    logic             r_overflow;
    logic             r_timeout;
    logic             r_res_valid;
    trace_rec_t       r_res_rec;

    logic       w_full, w_empty, w_pop, w_room, w_stall;
    logic       w_active, w_accept, w_is_halt, w_limit, w_tmo;
    logic       w_push, w_drop, w_res_load, w_res_clr;
    trace_kind_t w_kind;
    trace_rec_t w_ret_rec, w_tmo_rec, w_push_rec, w_res_rec, w_head, w_out;
    logic       w_unused;

    assign w_unused  = ^bus.retire_inst;
    assign w_pop     = !w_empty && bus.trace_ready;
    assign w_room    = !w_full || w_pop;
    assign w_active  = bus.run && (r_state == RUN);
`ifdef TRACE_STALL_EN
    assign w_stall   = w_full && (r_state == RUN) && !w_pop;
`else
    assign w_stall   = 1'b0;
`endif
    assign w_accept  = w_active && bus.retire_valid && !w_stall;
    assign w_is_halt = w_accept && bus.halt;
    assign w_limit   = w_active && (r_cycle_count == CNT_W'(CYCLE_LIMIT - 1));
    assign w_tmo     = w_limit && !w_is_halt;
    assign w_kind    = classify(bus.halt, bus.reg_write, bus.mem_read, bus.mem_write);

    always_comb begin
        w_ret_rec      = '0;
        w_ret_rec.kind = w_kind;
        w_ret_rec.inum = r_inst_count;
        w_ret_rec.pc   = bus.retire_pc;
        unique case (w_kind)
            REGWR: begin
                w_ret_rec.reg_idx = bus.write_reg;
                w_ret_rec.value   = bus.write_data;
            end
            LOAD: begin
                w_ret_rec.reg_idx = bus.write_reg;
                w_ret_rec.value   = bus.write_data;
                w_ret_rec.addr    = bus.mem_addr;
            end
            STORE: begin
                w_ret_rec.value   = bus.mem_data;
                w_ret_rec.addr    = bus.mem_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_tmo_rec      = '0;
        w_tmo_rec.kind = TIMEOUT;
        w_tmo_rec.inum = r_inst_count + CNT_W'(w_accept);
    end

    // Terminal records (HALT/TIMEOUT) fall back to the reserve slot instead of being
    // dropped; a retire coinciding with the watchdog takes the FIFO, TIMEOUT the reserve.
    always_comb begin
        w_push     = 1'b0;
        w_push_rec = w_ret_rec;
        w_drop     = 1'b0;
        w_res_load = 1'b0;
        w_res_rec  = w_tmo_rec;
        w_res_clr  = 1'b0;
        if (r_res_valid) begin
            if (w_room) begin
                w_push     = 1'b1;
                w_push_rec = r_res_rec;
                w_res_clr  = 1'b1;
            end
        end else begin
            if (w_accept) begin
                if (w_room) begin
                    w_push = 1'b1;
                end else if (w_is_halt) begin
                    w_res_load = 1'b1;
                    w_res_rec  = w_ret_rec;
                end else begin
                    w_drop = 1'b1;
                end
            end
            if (w_tmo) begin
                if (w_room && !w_accept) begin
                    w_push     = 1'b1;
                    w_push_rec = w_tmo_rec;
                end else begin
                    w_res_load = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            RUN:     if (w_is_halt || w_tmo) w_state_next = DRAIN;
            DRAIN:   if (bus.run && w_empty && !r_res_valid) w_state_next = DONE;
            DONE:    w_state_next = DONE;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_inst_count  <= '0;
            r_cycle_count <= '0;
            r_dropped     <= '0;
            r_overflow    <= 1'b0;
            r_timeout     <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_rec     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_inst_count <= r_inst_count + CNT_W'(1);
            if (w_active && (r_cycle_count != '1)) r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_drop) begin
                r_dropped  <= r_dropped + CNT_W'(1);
                r_overflow <= 1'b1;
            end
            if (w_tmo) r_timeout <= 1'b1;
            if (w_res_load) begin
                r_res_valid <= 1'b1;
                r_res_rec   <= w_res_rec;
            end else if (w_res_clr) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_out           = w_empty ? '0 : w_head;
    assign bus.stall       = w_stall;
    assign bus.trace_valid = !w_empty;
    assign bus.trace_kind  = w_out.kind;
    assign bus.trace_inum  = w_out.inum;
    assign bus.trace_pc    = w_out.pc;
    assign bus.trace_reg   = w_out.reg_idx;
    assign bus.trace_value = w_out.value;
    assign bus.trace_addr  = w_out.addr;
    assign bus.inst_count  = r_inst_count;
    assign bus.cycle_count = r_cycle_count;
    assign bus.dropped     = r_dropped;
    assign bus.overflow    = r_overflow;
    assign bus.timeout     = r_timeout;
    assign bus.done        = (r_state == DONE);

endmodule
